// File: rtl/exe_mul_sequencer_if.sv
// Operand/result bundle between the EXE stage and the multi-cycle multiply sequencer.
// The pipeline side is the master; the sequencer is the slave.
interface exe_mul_sequencer_if #(
  parameter int W = 32
);
  logic         start;
  logic         flush;
  logic [W-1:0] Val1;
  logic [W-1:0] Val2;
  logic [3:0]   SR_in;
  logic         stall;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   status;

  modport master (
    output start, flush, Val1, Val2, SR_in,
    input  stall, done, result, status
  );

  modport slave (
    input  start, flush, Val1, Val2, SR_in,
    output stall, done, result, status
  );
endinterface

// File: rtl/exe_mul_sequencer.sv
// Iterative shift-add multiplier for EXE: stalls 1+k cycles (k = top set bit of Val2 + 1),
// then strobes done for one cycle; flush aborts to IDLE without touching result/status.
module exe_mul_sequencer #(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  exe_mul_sequencer_if.slave   mul
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_mplier;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_result;
  logic [3:0]      r_status;

  logic            w_stall;
  logic            w_done;
  logic            w_latch;
  logic            w_step;
  logic            w_load_out;
  logic [W-1:0]    w_acc_step;
  logic [W-1:0]    w_mplier_shr;
  logic [W-1:0]    w_res_nxt;

  assign w_acc_step   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shr = r_mplier >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    w_latch     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mul.start && !mul.flush) begin
          w_stall     = 1'b1;
          w_latch     = 1'b1;
          w_state_nxt = (mul.Val2 == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_stall = 1'b1;
        if (mul.flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          // Stop as soon as no multiplier bits remain, or after the last bit position.
          if (w_mplier_shr == '0 || r_cnt == CNT_LAST) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_done      = ~mul.flush;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_load_out = (w_state_nxt == S_DONE) && (r_state != S_DONE);
  assign w_res_nxt  = (r_state == S_IDLE) ? '0 : w_acc_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_latch) begin
      r_mcand  <= mul.Val1;
      r_mplier <= mul.Val2;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= w_mplier_shr;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // C and V are not produced by MUL; they pass through from the current status register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_status <= '0;
    end else if (w_load_out) begin
      r_result <= w_res_nxt;
      r_status <= {w_res_nxt[W-1], (w_res_nxt == '0), mul.SR_in[1], mul.SR_in[0]};
    end
  end

  assign mul.stall  = w_stall;
  assign mul.done   = w_done;
  assign mul.result = r_result;
  assign mul.status = r_status;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Directed bench for exe_mul_sequencer: stall window length, done strobe, result/status,
// flush abort, back-to-back issue and asynchronous reset mid-run.
module tb_exe_mul_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  exe_mul_sequencer_if #(.W(W)) bus ();

  exe_mul_sequencer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .mul (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issues one MUL and follows it through the DONE cycle; keep=1 leaves start high
  // so the next call issues back-to-back.
  task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] sr, input int exp_st, input logic [W-1:0] exp_r,
                        input logic [3:0] exp_s, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Val1  = a;
    bus.Val2  = b;
    bus.SR_in = sr;
    #1;
    while (bus.stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_len"}, 64'(n), 64'(exp_st));
    chk({tag, "_done"},      64'(bus.done), 64'd1);
    chk({tag, "_result"},    64'(bus.result), 64'(exp_r));
    chk({tag, "_status"},    64'(bus.status), 64'(exp_s));
    if (!keep) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk({tag, "_done_drop"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle_stall"}, 64'(bus.stall), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.Val1  = '0;
    bus.Val2  = '0;
    bus.SR_in = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall",  64'(bus.stall),  64'd0);
    chk("rst_done",   64'(bus.done),   64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_status", 64'(bus.status), 64'd0);
    rst = 1'b0;

    // 7*6 = 42, C/V pass through
    do_mul("t1", 32'd7, 32'd6, 4'b0011, 4, 32'd42, 4'b0011, 1'b0);

    // Flush on the 10th stall cycle of 5 * 2^31
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Val1  = 32'd5;
    bus.Val2  = 32'h8000_0000;
    bus.SR_in = 4'b0000;
    #1;
    while (bus.stall === 1'b1 && n < 9) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("t5_reach10", 64'(n), 64'd9);
    bus.flush = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("t5_stall_in_flush", 64'(bus.stall), 64'd1);
    chk("t5_done_in_flush",  64'(bus.done),  64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("t5_stall_after", 64'(bus.stall),  64'd0);
    chk("t5_done_after",  64'(bus.done),   64'd0);
    chk("t5_result_kept", 64'(bus.result), 64'd42);
    chk("t5_status_kept", 64'(bus.status), 64'(4'b0011));
    @(negedge clk);
    #1;
    chk("t5_done_later", 64'(bus.done), 64'd0);

    // Flush and start together in IDLE: flush wins
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.Val2  = 32'd3;
    #1;
    chk("fs_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("fs_done", 64'(bus.done), 64'd0);
    chk("fs_stall_next", 64'(bus.stall), 64'd0);

    // Worst case: all ones squared
    do_mul("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1010, 33, 32'h0000_0001, 4'b0010, 1'b0);
    // Best case: zero multiplier
    do_mul("t3", 32'h1234_5678, 32'd0, 4'b0000, 1, 32'd0, 4'b0100, 1'b0);
    // Negative result: -2 * 3
    do_mul("t4", 32'hFFFF_FFFE, 32'd3, 4'b0000, 3, 32'hFFFF_FFFA, 4'b1000, 1'b0);

    // Back-to-back with start held: the DONE cycle is the single non-stall gap
    do_mul("t6a", 32'd3, 32'd3, 4'b0000, 3, 32'd9, 4'b0000, 1'b1);
    do_mul("t6b", 32'd4, 32'd5, 4'b0000, 4, 32'd20, 4'b0000, 1'b0);

    // Asynchronous reset mid-run
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.Val1  = 32'd5;
    bus.Val2  = 32'h8000_0000;
    bus.SR_in = 4'b0011;
    #1;
    while (bus.stall === 1'b1 && n < 5) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("rr_reach5", 64'(n), 64'd5);
    rst       = 1'b1;
    bus.start = 1'b0;
    #1;
    chk("rr_stall",  64'(bus.stall),  64'd0);
    chk("rr_done",   64'(bus.done),   64'd0);
    chk("rr_result", 64'(bus.result), 64'd0);
    chk("rr_status", 64'(bus.status), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("rr_no_done", 64'(bus.done), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exe_mul_sequencer.md
# exe_mul_sequencer

Multi-cycle multiply sequencer for the EXE stage. When the current EXE instruction is a MUL, it takes the forwarded operands (after the src1/src2 forwarding muxes) and runs an iterative shift-add multiply. It holds the pipeline with `stall` until the low W bits of the product are ready, then presents the result and the MUL status flags for one cycle. It sits beside the ALU: the EXE result mux selects `result` when `done` is high.

## Interface

- `W`, default 32: operand and result width. Must be ≥ 2.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  EXE holds a valid MUL instruction; held high while stalled
- `flush`  in  1  synchronous abort (branch taken / pipeline flush)
- `Val1`  in  W  multiplicand, forwarded src1
- `Val2`  in  W  multiplier, forwarded src2
- `SR_in`  in  4  current status register {N,Z,C,V}
- `stall`  out  1  freeze IF/ID/EXE; ID/EXE register holds its contents
- `done`  out  1  one-cycle strobe: `result` and `status` valid
- `result`  out  W  low W bits of Val1×Val2
- `status`  out  4  {N,Z,C,V} for MULS

## Operation

- FSM states: IDLE, RUN, DONE.
- Registers:
  - `mcand` (W), `mplier` (W), `acc` (W), `cnt` (ceil(log2 W) bits).
  - `result` (W) and `status` (4) are separate output registers.
- IDLE with `start`=1:
  - Latch `mcand`=Val1, `mplier`=Val2, `acc`=0, `cnt`=0.
  - If Val2==0, go to DONE; otherwise go to RUN.
- RUN, each cycle:
  - If `mplier[0]`, `acc` += `mcand` (mod 2^W).
  - `mcand` <<= 1, `mplier` >>= 1, `cnt`++.
  - Leave for DONE when the shifted `mplier` is 0 or `cnt` == W−1 (early termination).
- Entering DONE:
  - Load `result` from the final accumulator.
  - Load `status` = {result[W−1], result==0, SR_in[1], SR_in[0]}. C and V pass through unchanged.
- DONE:
  - `done`=1.
  - Always go to IDLE next cycle.
  - `start` is ignored in DONE; the same instruction is still presented while the pipeline advances.
- `stall` = (IDLE & `start` & ~`flush`) | RUN. It is combinational from `start` in IDLE and 0 in DONE.
- `flush` in any state:
  - Next state is IDLE.
  - `done` is not pulsed.
  - `result` and `status` keep their previous values.
- Product semantics: the low W bits of the product are identical for signed and unsigned operands. No sign handling is needed.
- `result` and `status` hold their value until the next DONE entry.

## Timing

- Reset: state IDLE; `acc`, `mcand`, `mplier`, `cnt`, `result` and `status` all 0; `done`=0; `stall`=0 while `start`=0.
- Steps k = (index of the highest set bit of Val2) + 1, with k=0 for Val2==0.
- `stall` is high for 1+k consecutive cycles, starting with the cycle in which `start` is first sampled in IDLE.
- `done` is high exactly one cycle, the cycle immediately after the last stalled cycle.
- Best case (Val2==0): 1 stall cycle. Worst case (Val2 bit W−1 set): 1+W stall cycles.
- Back-to-back MULs: the pipeline advances at the end of the DONE cycle. A new `start` is seen in IDLE the next cycle, so there is 1 idle-free gap cycle with no stall.
- `flush` and `start` in the same IDLE cycle: `flush` wins. `stall` stays 0 and no operands are latched.
- Asynchronous `rst` mid-RUN: immediate return to the reset values. No `done` is generated.

## Test plan

1. Val1=7, Val2=6, SR_in=4'b0011, `start` held: `stall` high 4 cycles, then `done`=1 for 1 cycle with `result`=42, `status`=4'b0011.
2. Val1=Val2=32'hFFFFFFFF: `stall` high 33 cycles, then `done` with `result`=32'h00000001, `status`={0,0,SR_in[1:0]}.
3. Val1=32'h12345678, Val2=0, SR_in=4'b0000: `stall` high 1 cycle, then `done` with `result`=0, `status`=4'b0100.
4. Val1=32'hFFFFFFFE (−2), Val2=3: `stall` high 3 cycles, then `result`=32'hFFFFFFFA, N=1, Z=0.
5. After test 1, start Val1=5, Val2=32'h80000000 and assert `flush` on the 10th stall cycle: the FSM is in IDLE next cycle, `stall` drops, `done` stays 0, and `result` remains 42.
6. Two MULs back-to-back (3×3, then 4×5) with `start` continuously high: `done` pulses 9 and then 20. Exactly one non-stall cycle (the DONE cycle) separates the two stall windows. Repeat with `rst` pulsed mid-RUN: all outputs are 0 and no `done` is produced.
